ship_motion_ctrl: RTL and testbench
===================================

# ship_motion_ctrl

Player-spaceship controller for the frame-rate game core: per frame it decodes held WASD keys from the USB keycode slots, moves and clamps the ship, tests it against OBJ_NUM enemy boxes, and runs a lives/invulnerability/game-over state machine. It sits between the keycode register and the sprite/draw logic, and feeds the score/HUD logic with hit and death events. It is the parametrised successor to the original single-life ship mover, adding configurable key slots, step size, lives, a post-hit invulnerability window and a blink output.

## Interface
- OBJ_NUM, 4, number of enemy collision inputs
- KEY_SLOTS, 3, number of 8-bit keycode slots scanned
- STEP, 3, pixels moved per frame per axis
- LIVES, 3, starting lives (1..15)
- INVULN_FRAMES, 120, invulnerable frames after a non-fatal hit (1..1023)
- X_MIN 9, X_MAX 630, Y_MIN 6, Y_MAX 473, playfield bounds
- SPAWN_X 320, SPAWN_Y 450, reset/respawn centre
- HALF_W 17, HALF_W_MOVE 14, HALF_H 16, half extents idle/moving
- frame_clk  in  1  frame clock (vsync-rate); sole clock
- Reset  in  1  synchronous, active-high reset
- keycode  in  8*KEY_SLOTS  held keycodes, slot i at [8i+7:8i]
- enemy_x, enemy_y, enemy_size  in  10 x OBJ_NUM each  enemy top-left and side length
- enemy_alive  in  1 x OBJ_NUM  enemy participates in collision
- ShipX, ShipY  out  10  ship centre
- Ship_W, Ship_H  out  10  current half-width / half-height
- left_move, right_move  out  1  horizontal motion flags
- lives  out  4  remaining lives
- hit_pulse  out  1  one-frame pulse on any counted hit
- hit_idx  out  clog2(OBJ_NUM)  enemy index of last counted hit
- invuln  out  1  ship in invulnerability window
- ship_visible  out  1  draw enable
- Ship_die  out  1  game over, held until Reset

## Operation
- Key decode: A=0x04, D=0x07, W=0x1A, S=0x16, matched in any slot. A wins over D; S wins over W.
- Horizontal: A -> X-STEP, D -> X+STEP; result clamped to [X_MIN+HALF_W, X_MAX-HALF_W]. Vertical likewise with HALF_H and Y bounds. Arithmetic in 11 bits before clamping, so no wrap at 0 or 1023.
- left_move/right_move registered from decode each frame; Ship_W = HALF_W_MOVE if either set, else HALF_W (combinational). Ship_H = HALF_H.
- Collision with enemy i (alive only): ShipX-Ship_W <= ex+es AND ShipY-HALF_H <= ey+es AND ShipX+Ship_W > ex AND ShipY+HALF_H > ey, evaluated on current registered values. Lowest colliding index wins hit_idx.
- States: PLAY, INVULN, OVER.
  - PLAY, collision: hit_pulse=1, hit_idx captured, lives-1. If lives was 1 -> OVER, lives=0, Ship_die=1, position frozen. Else -> INVULN, position = spawn (overrides movement), timer = INVULN_FRAMES-1.
  - INVULN: movement active, collisions ignored, invuln=1; timer decrements; when timer==0 at edge -> PLAY.
  - OVER: no movement, no collision, flags 0; only Reset exits.
- Reset values: ShipX=SPAWN_X, ShipY=SPAWN_Y, lives=LIVES, state PLAY, timer 0, hit_pulse 0, hit_idx 0, invuln 0, Ship_die 0, left/right_move 0, ship_visible 1.

## Timing
- All state updates on posedge frame_clk; one-frame latency from key to ShipX/ShipY.
- Collision sampled in frame N produces hit_pulse, lives change and respawn at edge N+1; hit_pulse low again at N+2 unless a new counted hit.
- INVULN lasts exactly INVULN_FRAMES frames; first collision-eligible frame is the one after invuln drops.
- Reset asserted mid-INVULN or in OVER restores all reset values at that edge; Reset wins over every other event.
- Simultaneous collision with several enemies costs one life only.

## Configuration
- SHIP_BLINK_EN defined: during INVULN, ship_visible = timer[3] inverted (8 frames on, 8 off, starting visible); 1 otherwise, 0 in OVER.
- Not defined: ship_visible = 1 in PLAY/INVULN, 0 in OVER.

## Test plan
- Reset, keycode slot1=0x07 for 10 frames -> ShipX 320->350, right_move=1, Ship_W=14; release -> Ship_W=17.
- Hold A with slot0=0x04 and D in slot2 for 200 frames -> A wins; ShipX clamps at 26, never below.
- Enemy 2 placed overlapping ship, LIVES=3 -> hit_pulse one frame, hit_idx=2, lives=2, ShipX/ShipY=320/450, invuln=1 for 120 frames, repeated overlap ignored.
- Enemies 1 and 3 overlapping same frame -> lives drops by 1 only, hit_idx=1.
- Three counted hits -> lives=0, Ship_die=1, keys ignored; Reset -> lives=3, Ship_die=0.
- SHIP_BLINK_EN build, after hit -> ship_visible pattern 8 high/8 low across INVULN, 1 after.

Source files
------------

// File: rtl/ship_motion_ctrl.sv
// ship_motion_ctrl: per-frame player ship controller.
// Decodes held WASD keys from the keycode slots, moves and clamps the ship,
// tests it against OBJ_NUM enemy boxes and runs the lives / invulnerability /
// game-over state machine.
// Optional feature macro: SHIP_BLINK_EN. When defined, the ship blinks
// (8 frames visible, 8 hidden) during the invulnerability window.
//
// Handshake note: there is no valid/ready flow here. Every output is a
// frame-rate register (except Ship_W/Ship_H, which are decoded from
// registers) and is valid for the whole frame after each frame_clk edge.
module ship_motion_ctrl #(
   parameter int OBJ_NUM       = 4,
   parameter int KEY_SLOTS     = 3,
   parameter int STEP          = 3,
   parameter int LIVES         = 3,
   parameter int INVULN_FRAMES = 120,
   parameter int X_MIN         = 9,
   parameter int X_MAX         = 630,
   parameter int Y_MIN         = 6,
   parameter int Y_MAX         = 473,
   parameter int SPAWN_X       = 320,
   parameter int SPAWN_Y       = 450,
   parameter int HALF_W        = 17,
   parameter int HALF_W_MOVE   = 14,
   parameter int HALF_H        = 16
) (
   input  logic                       frame_clk,
   input  logic                       Reset,
   input  logic [8*KEY_SLOTS-1:0]     keycode,
   input  logic [10*OBJ_NUM-1:0]      enemy_x,
   input  logic [10*OBJ_NUM-1:0]      enemy_y,
   input  logic [10*OBJ_NUM-1:0]      enemy_size,
   input  logic [OBJ_NUM-1:0]         enemy_alive,
   output logic [9:0]                 ShipX,
   output logic [9:0]                 ShipY,
   output logic [9:0]                 Ship_W,
   output logic [9:0]                 Ship_H,
   output logic                       left_move,
   output logic                       right_move,
   output logic [3:0]                 lives,
   output logic                       hit_pulse,
   output logic [$clog2(OBJ_NUM)-1:0] hit_idx,
   output logic                       invuln,
   output logic                       ship_visible,
   output logic                       Ship_die,
   output logic [1:0]                 state_dbg
);

   localparam int IDX_W = $clog2(OBJ_NUM);

   // Clamp limits use the idle half-width so the ship never leaves the field.
   localparam logic signed [11:0] X_LO   = 12'(X_MIN + HALF_W);
   localparam logic signed [11:0] X_HI   = 12'(X_MAX - HALF_W);
   localparam logic signed [11:0] Y_LO   = 12'(Y_MIN + HALF_H);
   localparam logic signed [11:0] Y_HI   = 12'(Y_MAX - HALF_H);
   localparam logic signed [11:0] STEP_S = 12'(STEP);
   localparam logic signed [11:0] HH_S   = 12'(HALF_H);

   localparam logic [9:0] SPAWN_X_L  = 10'(SPAWN_X);
   localparam logic [9:0] SPAWN_Y_L  = 10'(SPAWN_Y);
   localparam logic [9:0] INV_INIT   = 10'(INVULN_FRAMES - 1);
   localparam logic [3:0] LIVES_L    = 4'(LIVES);

   localparam logic [7:0] KEY_A = 8'h04;
   localparam logic [7:0] KEY_D = 8'h07;
   localparam logic [7:0] KEY_W = 8'h1A;
   localparam logic [7:0] KEY_S = 8'h16;

`ifdef SHIP_BLINK_EN
   localparam logic NO_BLINK = 1'b0;
`else
   localparam logic NO_BLINK = 1'b1;
`endif

   typedef enum logic [1:0] {
      PLAY   = 2'd0,
      INVULN = 2'd1,
      OVER   = 2'd2
   } state_t;

   state_t state;
   logic [9:0] timer;

   logic key_a, key_d, key_w, key_s;
   logic go_left, go_right, go_up, go_down;
   logic signed [11:0] x_s, y_s, x_mv, y_mv, x_cl, y_cl;
   logic signed [11:0] ship_l, ship_r, ship_t, ship_b;
   logic hit_any;
   logic [IDX_W-1:0] hit_sel;

   // Zero-extend a 10-bit coordinate into signed 12-bit working space.
   function automatic logic signed [11:0] ext(input logic [9:0] v);
      return {2'b00, v};
   endfunction

   // Visibility for a given remaining invulnerability count: bit 3 low = shown.
   function automatic logic blink_vis(input logic [9:0] t);
      return NO_BLINK | ~t[3];
   endfunction

   assign Ship_W    = (left_move || right_move) ? 10'(HALF_W_MOVE) : 10'(HALF_W);
   assign Ship_H    = 10'(HALF_H);
   assign state_dbg = state;

   // Scan every keycode slot for the four movement keys; A beats D, S beats W.
   always_comb begin
      key_a = 1'b0;
      key_d = 1'b0;
      key_w = 1'b0;
      key_s = 1'b0;
      for (int i = 0; i < KEY_SLOTS; i++) begin
         if (keycode[8*i +: 8] == KEY_A) key_a = 1'b1;
         if (keycode[8*i +: 8] == KEY_D) key_d = 1'b1;
         if (keycode[8*i +: 8] == KEY_W) key_w = 1'b1;
         if (keycode[8*i +: 8] == KEY_S) key_s = 1'b1;
      end
      go_left  = key_a;
      go_right = key_d & ~key_a;
      go_down  = key_s;
      go_up    = key_w & ~key_s;
   end

   // Candidate next position: step in 12-bit signed space, then clamp.
   always_comb begin
      x_s = ext(ShipX);
      y_s = ext(ShipY);
      x_mv = x_s;
      y_mv = y_s;
      if (go_left)       x_mv = x_s - STEP_S;
      else if (go_right) x_mv = x_s + STEP_S;
      if (go_down)       y_mv = y_s + STEP_S;
      else if (go_up)    y_mv = y_s - STEP_S;
      x_cl = x_mv;
      y_cl = y_mv;
      if (x_mv < X_LO)      x_cl = X_LO;
      else if (x_mv > X_HI) x_cl = X_HI;
      if (y_mv < Y_LO)      y_cl = Y_LO;
      else if (y_mv > Y_HI) y_cl = Y_HI;
   end

   // Box overlap against every live enemy; scanning downward leaves the lowest hit index.
   always_comb begin
      ship_l  = ext(ShipX) - ext(Ship_W);
      ship_r  = ext(ShipX) + ext(Ship_W);
      ship_t  = ext(ShipY) - HH_S;
      ship_b  = ext(ShipY) + HH_S;
      hit_any = 1'b0;
      hit_sel = '0;
      for (int i = OBJ_NUM - 1; i >= 0; i--) begin
         if (enemy_alive[i] &&
             (ship_l <= ext(enemy_x[10*i +: 10]) + ext(enemy_size[10*i +: 10])) &&
             (ship_t <= ext(enemy_y[10*i +: 10]) + ext(enemy_size[10*i +: 10])) &&
             (ship_r >  ext(enemy_x[10*i +: 10])) &&
             (ship_b >  ext(enemy_y[10*i +: 10]))) begin
            hit_any = 1'b1;
            hit_sel = IDX_W'(i);
         end
      end
   end

   // Lives / invulnerability / game-over state machine with registered outputs.
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state        <= PLAY;
         timer        <= '0;
         ShipX        <= SPAWN_X_L;
         ShipY        <= SPAWN_Y_L;
         lives        <= LIVES_L;
         hit_pulse    <= 1'b0;
         hit_idx      <= '0;
         invuln       <= 1'b0;
         Ship_die     <= 1'b0;
         left_move    <= 1'b0;
         right_move   <= 1'b0;
         ship_visible <= 1'b1;
      end else begin
         hit_pulse <= 1'b0;
         case (state)
            PLAY: begin
               if (hit_any) begin
                  hit_pulse <= 1'b1;
                  hit_idx   <= hit_sel;
                  if (lives == 4'd1) begin
                     // Last life: freeze where we are and stay dead until reset.
                     state        <= OVER;
                     lives        <= 4'd0;
                     Ship_die     <= 1'b1;
                     invuln       <= 1'b0;
                     ship_visible <= 1'b0;
                     left_move    <= 1'b0;
                     right_move   <= 1'b0;
                  end else begin
                     // Respawn overrides any movement requested this frame.
                     state        <= INVULN;
                     lives        <= lives - 4'd1;
                     ShipX        <= SPAWN_X_L;
                     ShipY        <= SPAWN_Y_L;
                     timer        <= INV_INIT;
                     invuln       <= 1'b1;
                     ship_visible <= blink_vis(INV_INIT);
                     left_move    <= go_left;
                     right_move   <= go_right;
                  end
               end else begin
                  ShipX      <= x_cl[9:0];
                  ShipY      <= y_cl[9:0];
                  left_move  <= go_left;
                  right_move <= go_right;
               end
            end
            INVULN: begin
               ShipX      <= x_cl[9:0];
               ShipY      <= y_cl[9:0];
               left_move  <= go_left;
               right_move <= go_right;
               if (timer == 10'd0) begin
                  state        <= PLAY;
                  invuln       <= 1'b0;
                  ship_visible <= 1'b1;
               end else begin
                  timer        <= timer - 10'd1;
                  ship_visible <= blink_vis(timer - 10'd1);
               end
            end
            OVER: begin
               left_move    <= 1'b0;
               right_move   <= 1'b0;
               invuln       <= 1'b0;
               ship_visible <= 1'b0;
            end
            default: begin
               state <= PLAY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ship_motion_ctrl.sv
// Testbench for ship_motion_ctrl: directed frame-by-frame stimulus with
// hand-computed expectations pushed into a queue and checked by a monitor.
module tb_ship_motion_ctrl;

   logic        frame_clk = 1'b0;
   logic        Reset;
   logic [23:0] keycode;
   logic [39:0] enemy_x;
   logic [39:0] enemy_y;
   logic [39:0] enemy_size;
   logic [3:0]  enemy_alive;
   logic [9:0]  ShipX, ShipY, Ship_W, Ship_H;
   logic        left_move, right_move;
   logic [3:0]  lives;
   logic        hit_pulse;
   logic [1:0]  hit_idx;
   logic        invuln, ship_visible, Ship_die;
   logic [1:0]  state_dbg;

   ship_motion_ctrl dut (
      .frame_clk    (frame_clk),
      .Reset        (Reset),
      .keycode      (keycode),
      .enemy_x      (enemy_x),
      .enemy_y      (enemy_y),
      .enemy_size   (enemy_size),
      .enemy_alive  (enemy_alive),
      .ShipX        (ShipX),
      .ShipY        (ShipY),
      .Ship_W       (Ship_W),
      .Ship_H       (Ship_H),
      .left_move    (left_move),
      .right_move   (right_move),
      .lives        (lives),
      .hit_pulse    (hit_pulse),
      .hit_idx      (hit_idx),
      .invuln       (invuln),
      .ship_visible (ship_visible),
      .Ship_die     (Ship_die),
      .state_dbg    (state_dbg)
   );

   // ---------------- clock ----------------
   always #5 frame_clk = ~frame_clk;

   // ---------------- scoreboard ----------------
   typedef struct {
      int    frame;
      string nm;
      int    x, y, w, lm, rm, lv, hp, idx, inv, vis, die;
   } exp_t;

   exp_t exp_q[$];
   int   frame_no = 0;
   int   checks   = 0;
   int   errors   = 0;

   task automatic cmp(input string nm, input int frm, input string fld,
                      input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s frame %0d %s: got %0d expected %0d", nm, frm, fld, act, exp);
      end
   endtask

   // Monitor: outputs are registered, so every edge presents a new frame of outputs.
   always @(posedge frame_clk) begin
      exp_t e;
      frame_no++;
      #1;
      while (exp_q.size() > 0 && exp_q[0].frame <= frame_no) begin
         e = exp_q.pop_front();
         if (e.frame < frame_no) begin
            cmp(e.nm, e.frame, "stale_expectation", frame_no, e.frame);
         end else begin
            cmp(e.nm, e.frame, "ShipX",        int'(ShipX),        e.x);
            cmp(e.nm, e.frame, "ShipY",        int'(ShipY),        e.y);
            cmp(e.nm, e.frame, "Ship_W",       int'(Ship_W),       e.w);
            cmp(e.nm, e.frame, "Ship_H",       int'(Ship_H),       16);
            cmp(e.nm, e.frame, "left_move",    int'(left_move),    e.lm);
            cmp(e.nm, e.frame, "right_move",   int'(right_move),   e.rm);
            cmp(e.nm, e.frame, "lives",        int'(lives),        e.lv);
            cmp(e.nm, e.frame, "hit_pulse",    int'(hit_pulse),    e.hp);
            cmp(e.nm, e.frame, "hit_idx",      int'(hit_idx),      e.idx);
            cmp(e.nm, e.frame, "invuln",       int'(invuln),       e.inv);
            cmp(e.nm, e.frame, "ship_visible", int'(ship_visible), e.vis);
            cmp(e.nm, e.frame, "Ship_die",     int'(Ship_die),     e.die);
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Queue the expected outputs after the coming edge, then advance one frame.
   task automatic chk(input string nm, input int x, input int y, input int w,
                      input int lm, input int rm, input int lv, input int hp,
                      input int idx, input int inv, input int vis, input int die);
      exp_t e;
      e.frame = frame_no + 1;
      e.nm = nm;
      e.x = x; e.y = y; e.w = w; e.lm = lm; e.rm = rm; e.lv = lv;
      e.hp = hp; e.idx = idx; e.inv = inv; e.vis = vis; e.die = die;
      exp_q.push_back(e);
      @(negedge frame_clk);
   endtask

   task automatic set_enemy(input int i, input int x, input int y, input int s);
      enemy_x[i*10 +: 10]    = 10'(x);
      enemy_y[i*10 +: 10]    = 10'(y);
      enemy_size[i*10 +: 10] = 10'(s);
   endtask

   // Frame j of the invulnerability window (j=0 is the hit frame).
   function automatic int exp_vis(input int j);
`ifdef SHIP_BLINK_EN
      return ((j / 8) % 2 == 0) ? 1 : 0;
`else
      return (j >= 0) ? 1 : 0;
`endif
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int ex, ey;
      Reset       = 1'b1;
      keycode     = '0;
      enemy_x     = '0;
      enemy_y     = '0;
      enemy_size  = '0;
      enemy_alive = '0;
      @(negedge frame_clk);
      chk("reset", 320, 450, 17, 0, 0, 3, 0, 0, 0, 1, 0);
      Reset = 1'b0;

      // D held in slot 1: +3 per frame
      keycode = 24'h000700;
      for (int k = 1; k <= 10; k++)
         chk("right_d", 320 + 3*k, 450, 14, 0, 1, 3, 0, 0, 0, 1, 0);
      keycode = 24'h000000;
      chk("release", 350, 450, 17, 0, 0, 3, 0, 0, 0, 1, 0);

      // A in slot 0 and D in slot 2: A wins, clamp at 9+17=26
      keycode = 24'h070004;
      for (int k = 1; k <= 200; k++) begin
         ex = 350 - 3*k;
         if (ex < 26) ex = 26;
         chk("left_clamp", ex, 450, 14, 1, 0, 3, 0, 0, 0, 1, 0);
      end

      // W and S together: S wins, clamp at 473-16=457
      keycode = 24'h1A1600;
      for (int k = 1; k <= 4; k++) begin
         ey = 450 + 3*k;
         if (ey > 457) ey = 457;
         chk("s_wins", 26, ey, 17, 0, 0, 3, 0, 0, 0, 1, 0);
      end
      keycode = 24'h00001A;
      chk("w_up", 26, 454, 17, 0, 0, 3, 0, 0, 0, 1, 0);
      keycode = 24'h000000;

      // Enemy 2 overlapping ship at (26,454): first hit, respawn
      set_enemy(2, 20, 440, 20);
      enemy_alive = 4'b0100;
      chk("hit1", 320, 450, 17, 0, 0, 2, 1, 2, 1, exp_vis(0), 0);

      // Enemy 2 moved onto spawn: ignored while invulnerable; D for one frame
      set_enemy(2, 310, 440, 20);
      for (int j = 1; j <= 119; j++) begin
         keycode = (j == 5) ? 24'h000007 : 24'h000000;
         chk("invuln1", (j >= 5) ? 323 : 320, 450, (j == 5) ? 14 : 17,
             0, (j == 5) ? 1 : 0, 2, 0, 2, 1, exp_vis(j), 0);
      end
      keycode = 24'h000000;
      set_enemy(1, 310, 440, 20);
      set_enemy(3, 310, 440, 20);
      enemy_alive = 4'b1010;
      chk("invuln1_end", 323, 450, 17, 0, 0, 2, 0, 2, 0, 1, 0);

      // Enemies 1 and 3 overlap together: one life, lowest index
      chk("hit2_multi", 320, 450, 17, 0, 0, 1, 1, 1, 1, exp_vis(0), 0);
      enemy_alive = 4'b0000;
      for (int j = 1; j <= 119; j++)
         chk("invuln2", 320, 450, 17, 0, 0, 1, 0, 1, 1, exp_vis(j), 0);
      set_enemy(0, 310, 440, 20);
      enemy_alive = 4'b0001;
      chk("invuln2_end", 320, 450, 17, 0, 0, 1, 0, 1, 0, 1, 0);

      // Last life lost: game over, frozen
      chk("hit3_over", 320, 450, 17, 0, 0, 0, 1, 0, 0, 0, 1);
      keycode = 24'h000004;
      for (int k = 0; k < 5; k++)
         chk("over_frozen", 320, 450, 17, 0, 0, 0, 0, 0, 0, 0, 1);

      // Reset wins over held key in OVER
      Reset = 1'b1;
      chk("reset_over", 320, 450, 17, 0, 0, 3, 0, 0, 0, 1, 0);
      Reset = 1'b0;
      enemy_alive = 4'b0000;
      chk("after_reset_move", 317, 450, 14, 1, 0, 3, 0, 0, 0, 1, 0);
      keycode = 24'h000000;

      @(negedge frame_clk);
      @(negedge frame_clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
